// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain stream loader.
package ccff_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/ccff_byte_serializer.sv
// Byte-wide load/shift buffer, MSB first, with a count of bits still held.
module ccff_byte_serializer
    import ccff_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              discard_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              bit_o,
    output logic              empty_o,
    output logic              last_bit_o,
    output logic              nonempty_next_o
);

    logic [BYTE_W-1:0]    buf_q, buf_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

    // A load on the same edge as the final shift replaces the spent bit, so
    // consecutive bytes stream without a gap.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (discard_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            buf_d = data_i;
            cnt_d = BIT_CNT_W'(BYTE_W);
        end else if (shift_i && (cnt_q != '0)) begin
            buf_d = {buf_q[BYTE_W-2:0], 1'b0};
            cnt_d = cnt_q - BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o           = buf_q[BYTE_W-1];
    assign empty_o         = (cnt_q == '0);
    assign last_bit_o      = (cnt_q == BIT_CNT_W'(1));
    assign nonempty_next_o = (cnt_d != '0);

endmodule

// File: rtl/ccff_stream_loader.sv
// Serializes handshaked bitstream bytes onto a tile's ccff chain and counts
// the ones that emerge from the chain tail while loading.
module ccff_stream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned STALL_MAX = 255,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]   tail_q, tail_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               shift_en_q, shift_en_d;

    logic ser_load, ser_shift, ser_discard;
    logic ser_bit, ser_empty, ser_last, ser_nonempty_next;
    logic accept;

    ccff_byte_serializer u_ser (
        .clk_i           (prog_clk),
        .rst_i           (pReset),
        .load_i          (ser_load),
        .shift_i         (ser_shift),
        .discard_i       (ser_discard),
        .data_i          (data_in),
        .bit_o           (ser_bit),
        .empty_o         (ser_empty),
        .last_bit_o      (ser_last),
        .nonempty_next_o (ser_nonempty_next)
    );

    // A byte is wanted only while the chain still needs bits beyond the one on ccff_head.
    assign data_ready = (state_q == LOAD) &&
                        (ser_empty || (ser_last && (bits_left_q > CNT_W'(1))));
    assign accept     = data_ready && data_valid;

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        tail_d      = tail_q;
        stall_d     = stall_q;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        ser_discard = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            stall_d     = '0;
            ser_discard = 1'b1;
            if (shift_en_q && ccff_tail) begin
                tail_d = tail_q + CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_d     = LOAD;
                        bits_left_d = CNT_W'(CHAIN_LEN);
                        tail_d      = '0;
                        stall_d     = '0;
                        ser_discard = 1'b1;
                    end
                end
                LOAD: begin
                    ser_load = accept;
                    if (shift_en_q) begin
                        ser_shift   = 1'b1;
                        bits_left_d = bits_left_q - CNT_W'(1);
                        if (ccff_tail) begin
                            tail_d = tail_q + CNT_W'(1);
                        end
                    end
                    if (accept) begin
                        stall_d = '0;
                    end else if (ser_empty) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                    if (shift_en_q && (bits_left_q == CNT_W'(1))) begin
                        state_d     = DONE;
                        ser_discard = 1'b1;
                    end else if (!accept && ser_empty &&
                                 (stall_q == STALL_W'(STALL_MAX - 1))) begin
                        state_d = ERROR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        shift_en_d = (state_d == LOAD) && ser_nonempty_next && (bits_left_d != '0);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            tail_q      <= '0;
            stall_q     <= '0;
            shift_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            tail_q      <= tail_d;
            stall_q     <= stall_d;
            shift_en_q  <= shift_en_d;
        end
    end

    assign ccff_head     = ser_bit;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q == LOAD);
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERROR);
    assign tail_ones     = tail_q;

endmodule

// File: doc/ccff_stream_loader.md
Name: ccff_stream_loader

Overview:
- Upstream configuration-chain driver for a CLB tile. It accepts bitstream bytes over a valid/ready handshake and serializes them onto the tile's ccff_head.
- It produces a shift enable for the prog_clk gating cell, so the chain advances only on valid bits.
- It counts the bits that emerge on ccff_tail, giving a readback popcount of the previous configuration.
- It runs on the programming clock domain only, between the bitstream port and the tile chain head.

Parameters:
- CHAIN_LEN, 1024: total configuration bits in the downstream chain (any value >= 1).
- STALL_MAX, 255: maximum consecutive cycles with no byte available in LOAD before an error is declared.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter and the readback counter.

Ports:
- prog_clk  input  1  sole clock. All state updates on the rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load. Honoured in IDLE, DONE and ERROR only.
- abort  input  1  returns the block to IDLE on the next edge from any state.
- data_in  input  8  bitstream byte. MSB is shifted first.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  the byte is taken on an edge where data_valid && data_ready.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  enable for the prog_clk gate. The chain shifts on each edge where this is 1.
- ccff_tail  input  1  serial bit out of the chain end.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- error  output  1  high in ERROR (stall timeout).
- tail_ones  output  CNT_W  count of ccff_tail==1 sampled on shift edges during the current/last load.

Behaviour:
- Reset (pReset=1 on an edge): state=IDLE. data_ready, ccff_head, ccff_shift_en, busy, done and error all =0. tail_ones=0. Internal counters and buffers cleared.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - next state LOAD;
  - bit counter = CHAIN_LEN;
  - tail_ones = 0;
  - stall counter = 0;
  - shift buffer empty.
- LOAD, byte handshake:
  - data_ready = 1 when the shift buffer is empty, or when it holds exactly 1 remaining bit (no bubble between bytes).
  - data_ready is combinational from state and buffer count only, never from data_valid.
- LOAD, shifting:
  - Each cycle the buffer holds a bit and bits remain: ccff_head = next bit (data_in[7] first), ccff_shift_en = 1.
  - Both outputs are registered and change together.
  - On each edge with ccff_shift_en=1: bit counter decrements, and tail_ones increments if ccff_tail==1.
- Throughput: back-to-back valid bytes give continuous ccff_shift_en. The first ccff_shift_en=1 appears 1 cycle after the accepting edge.
- Partial last byte: when the bit counter reaches 0 mid-byte, the remaining buffered bits are discarded. data_ready goes low in the same cycle.
- Completion: when the edge that shifts the last bit occurs, next state is DONE and ccff_shift_en = 0. Bytes offered afterwards are not accepted.
- Stall:
  - In LOAD, a cycle with the buffer empty, no handshake and bits remaining increments the stall counter. Any accepted byte clears it.
  - When the counter reaches STALL_MAX, next state is ERROR and ccff_shift_en = 0.
- tail_ones is held in DONE and ERROR until the next start.
- abort has priority over start and over completion in the same cycle. It leads to IDLE with tail_ones held.
- start during LOAD is ignored.
- pReset overrides everything.
- ccff_shift_en is never 1 outside LOAD.

Decomposition:
- Package ccff_loader_pkg: the state enum (IDLE, LOAD, DONE, ERROR) and the constant BYTE_W = 8.
- One sub-module, ccff_byte_serializer: an 8-bit load/shift buffer with a remaining-bit count. It has a load, shift, discard interface and exposes empty and last_bit flags.
- The FSM, stall counter and tail counter live in the top module.

Test Plan:
- CHAIN_LEN=16, start, then bytes 0xA5, 0x3C sent back-to-back -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 consecutive cycles with ccff_shift_en=1. done=1 on the following cycle. No third byte is accepted.
- CHAIN_LEN=12, bytes 0xFF, 0x0F -> 12 shift cycles: eight 1s, then 0,0,0,0. The low nibble of the second byte is discarded. done=1.
- Tail readback: model the chain as a 16-bit shift register. Load 0xA5, 0x3C, then reload 0x00, 0x00 -> tail_ones=8 after the second load.
- Stall with STALL_MAX=4: start, one byte, then data_valid held low -> error=1 exactly 4 cycles after the buffer empties. ccff_shift_en=0 from then. start recovers to LOAD.
- abort in the 5th shift cycle -> IDLE next edge, ccff_shift_en=0, data_ready=0, tail_ones held.
- Synchronous pReset asserted mid-LOAD -> all outputs 0 on the next edge. pReset held low but unclocked has no effect.
